// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - select sequencer for a glitch-free two-input clock mux
// Handles requested switches, failover on a dead clock, ack timeout and post-switch dwell.
module clk_switch_ctrl #(
   parameter int unsigned DWELL_CYC   = 16,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_valid_i,
   input  logic req_sel_i,
   output logic req_ready_o,
   input  logic clk0_alive_i,
   input  logic clk1_alive_i,
   input  logic sel_ack_i,
   output logic select_o,
   output logic cur_sel_o,
   output logic busy_o,
   output logic done_o,
   output logic err_timeout_o,
   output logic err_dead_o,
   output logic failover_o
);

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [15:0] DWELL_LAST   = 16'(DWELL_CYC - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      DWELL    = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        select_q, select_d;
   logic        cur_sel_q, cur_sel_d;
   logic [15:0] timer_q, timer_d;
   logic        done_q, done_d;
   logic        err_timeout_q, err_timeout_d;
   logic        err_dead_q, err_dead_d;
   logic        failover_q, failover_d;
   logic        req_ready;

   logic        alive0_meta_q, alive0_s_q;
   logic        alive1_meta_q, alive1_s_q;
   logic        ack_meta_q, ack_s_q;

   logic        cur_alive, other_alive, req_alive, failover_now;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         alive0_meta_q <= 1'b0;
         alive0_s_q    <= 1'b0;
         alive1_meta_q <= 1'b0;
         alive1_s_q    <= 1'b0;
         ack_meta_q    <= 1'b0;
         ack_s_q       <= 1'b0;
      end else begin
         alive0_meta_q <= clk0_alive_i;
         alive0_s_q    <= alive0_meta_q;
         alive1_meta_q <= clk1_alive_i;
         alive1_s_q    <= alive1_meta_q;
         ack_meta_q    <= sel_ack_i;
         ack_s_q       <= ack_meta_q;
      end
   end

   assign cur_alive    = cur_sel_q ? alive1_s_q : alive0_s_q;
   assign other_alive  = cur_sel_q ? alive0_s_q : alive1_s_q;
   assign req_alive    = req_sel_i ? alive1_s_q : alive0_s_q;
   assign failover_now = !cur_alive && other_alive;

   always_comb begin
      state_d       = state_q;
      select_d      = select_q;
      cur_sel_d     = cur_sel_q;
      timer_d       = timer_q;
      done_d        = 1'b0;
      err_timeout_d = 1'b0;
      err_dead_d    = 1'b0;
      failover_d    = 1'b0;
      req_ready     = 1'b0;

      case (state_q)
         IDLE: begin
            if (failover_now) begin
               select_d   = ~cur_sel_q;
               failover_d = 1'b1;
               timer_d    = 16'd0;
               state_d    = WAIT_ACK;
            end else begin
               req_ready = 1'b1;
               if (req_valid_i) begin
                  if (req_sel_i == cur_sel_q) begin
                     done_d = 1'b1;
                  end else if (!req_alive) begin
                     err_dead_d = 1'b1;
                  end else begin
                     select_d = req_sel_i;
                     timer_d  = 16'd0;
                     state_d  = WAIT_ACK;
                  end
               end
            end
         end

         WAIT_ACK: begin
            // An ack match on the final timer cycle still counts as success.
            if (ack_s_q == select_q) begin
               cur_sel_d = select_q;
               done_d    = 1'b1;
               timer_d   = 16'd0;
               state_d   = DWELL;
            end else if (timer_q == TIMEOUT_LAST) begin
               select_d      = cur_sel_q;
               err_timeout_d = 1'b1;
               timer_d       = 16'd0;
               state_d       = DWELL;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end

         DWELL: begin
            if (timer_q == DWELL_LAST) begin
               timer_d = 16'd0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end

         default: begin
            timer_d = 16'd0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         select_q      <= 1'b0;
         cur_sel_q     <= 1'b0;
         timer_q       <= 16'd0;
         done_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_dead_q    <= 1'b0;
         failover_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         select_q      <= select_d;
         cur_sel_q     <= cur_sel_d;
         timer_q       <= timer_d;
         done_q        <= done_d;
         err_timeout_q <= err_timeout_d;
         err_dead_q    <= err_dead_d;
         failover_q    <= failover_d;
      end
   end

   assign req_ready_o   = req_ready && !rst_i;
   assign busy_o        = (state_q != IDLE) && !rst_i;
   assign select_o      = select_q;
   assign cur_sel_o     = cur_sel_q;
   assign done_o        = done_q;
   assign err_timeout_o = err_timeout_q;
   assign err_dead_o    = err_dead_q;
   assign failover_o    = failover_q;

endmodule
